// File: rtl/cut_search_arbiter_if.sv
// rtl/cut_search_arbiter_if.sv - requester, engine and result bundle for cut_search_arbiter
interface cut_search_arbiter_if #(
   parameter int NUM_REQ     = 4,
   parameter int TAG_WIDTH   = 32,
   parameter int BLOCKLENGTH = 6,
   parameter int DATA_WIDTH  = 8
);
   localparam int ID_WIDTH = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]                        req_valid;
   logic [NUM_REQ-1:0]                        req_ready;
   logic [NUM_REQ*TAG_WIDTH-1:0]              req_tag;
   logic [NUM_REQ*DATA_WIDTH*BLOCKLENGTH-1:0] req_data;
   logic                                      eng_valid;
   logic                                      eng_accept;
   logic [ID_WIDTH+TAG_WIDTH-1:0]             eng_tag;
   logic [DATA_WIDTH*BLOCKLENGTH-1:0]         eng_data;
   logic                                      res_valid;
   logic                                      res_ready;
   logic [ID_WIDTH+TAG_WIDTH-1:0]             res_tag;
   logic [BLOCKLENGTH-1:0]                    res_data;
   logic [NUM_REQ-1:0]                        out_valid;
   logic [NUM_REQ-1:0]                        out_ready;
   logic [TAG_WIDTH-1:0]                      out_tag;
   logic [BLOCKLENGTH-1:0]                    out_data;
   logic                                      busy;
   logic                                      err;

   modport master (
      output req_valid, req_tag, req_data, eng_accept, res_valid, res_tag, res_data, out_ready,
      input  req_ready, eng_valid, eng_tag, eng_data, res_ready, out_valid, out_tag, out_data,
             busy, err
   );

   modport slave (
      input  req_valid, req_tag, req_data, eng_accept, res_valid, res_tag, res_data, out_ready,
      output req_ready, eng_valid, eng_tag, eng_data, res_ready, out_valid, out_tag, out_data,
             busy, err
   );
endinterface

// File: rtl/cut_search_arbiter.sv
// rtl/cut_search_arbiter.sv - round-robin credit arbiter sharing one cut-search engine
module cut_search_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int TAG_WIDTH    = 32,
   parameter int BLOCKLENGTH  = 6,
   parameter int DATA_WIDTH   = 8,
   parameter int MAX_INFLIGHT = 8
) (
   input logic                 clk,
   input logic                 reset,
   cut_search_arbiter_if.slave bus
);
   localparam int ID_WIDTH  = $clog2(NUM_REQ);
   localparam int VEC_WIDTH = DATA_WIDTH * BLOCKLENGTH;
   localparam int CNT_WIDTH = $clog2(MAX_INFLIGHT + 1);

   logic [ID_WIDTH-1:0]           ptr_q, ptr_d;
   logic [CNT_WIDTH-1:0]          inflight_q, inflight_d;
   logic                          eng_valid_q, eng_valid_d;
   logic [ID_WIDTH+TAG_WIDTH-1:0] eng_tag_q, eng_tag_d;
   logic [VEC_WIDTH-1:0]          eng_data_q, eng_data_d;
   logic                          hold_q, hold_d;
   logic [ID_WIDTH-1:0]           out_id_q, out_id_d;
   logic [TAG_WIDTH-1:0]          out_tag_q, out_tag_d;
   logic [BLOCKLENGTH-1:0]        out_data_q, out_data_d;
   logic                          err_q, err_d;

   logic [NUM_REQ-1:0]   grant;
   logic                 grant_any;
   logic [ID_WIDTH-1:0]  grant_id;
   logic [TAG_WIDTH-1:0] grant_tag;
   logic [VEC_WIDTH-1:0] grant_data;
   logic [ID_WIDTH-1:0]  ptr_next;
   logic [NUM_REQ-1:0]   out_valid;
   logic [ID_WIDTH-1:0]  res_id;
   logic                 res_id_ok;
   logic                 delivery;
   logic                 res_ready;
   logic                 res_take;
   logic                 res_drop;
   int                   idx;
   int                   cnt_next;

   // Grants are suppressed while reset is held so req_ready stays low during reset.
   always_comb begin
      grant      = '0;
      grant_any  = 1'b0;
      grant_id   = '0;
      grant_tag  = '0;
      grant_data = '0;
      ptr_next   = ptr_q;
      idx        = 0;
      if (!reset && (!eng_valid_q || bus.eng_accept) &&
          (inflight_q < CNT_WIDTH'(MAX_INFLIGHT))) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_any && bus.req_valid[idx]) begin
               grant_any   = 1'b1;
               grant[idx]  = 1'b1;
               grant_id    = ID_WIDTH'(idx);
               grant_tag   = bus.req_tag[idx*TAG_WIDTH +: TAG_WIDTH];
               grant_data  = bus.req_data[idx*VEC_WIDTH +: VEC_WIDTH];
               if (idx + 1 == NUM_REQ) ptr_next = '0;
               else                    ptr_next = ID_WIDTH'(idx + 1);
            end
         end
      end
   end

   assign res_id = bus.res_tag[ID_WIDTH+TAG_WIDTH-1 -: ID_WIDTH];

   always_comb begin
      out_valid = '0;
      res_id_ok = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (hold_q && (out_id_q == ID_WIDTH'(k))) out_valid[k] = 1'b1;
         if (res_id == ID_WIDTH'(k)) res_id_ok = 1'b1;
      end
   end

   assign delivery  = |(out_valid & bus.out_ready);
   assign res_ready = !hold_q || delivery;
   assign res_take  = bus.res_valid && res_ready && res_id_ok;
   assign res_drop  = bus.res_valid && res_ready && !res_id_ok;

   always_comb begin
      ptr_d       = ptr_q;
      eng_valid_d = eng_valid_q;
      eng_tag_d   = eng_tag_q;
      eng_data_d  = eng_data_q;
      hold_d      = hold_q;
      out_id_d    = out_id_q;
      out_tag_d   = out_tag_q;
      out_data_d  = out_data_q;
      err_d       = err_q | res_drop;
      cnt_next    = 0;

      if (grant_any) begin
         ptr_d       = ptr_next;
         eng_valid_d = 1'b1;
         eng_tag_d   = {grant_id, grant_tag};
         eng_data_d  = grant_data;
      end else if (bus.eng_accept) begin
         eng_valid_d = 1'b0;
      end

      if (res_take) begin
         hold_d     = 1'b1;
         out_id_d   = res_id;
         out_tag_d  = bus.res_tag[TAG_WIDTH-1:0];
         out_data_d = bus.res_data;
      end else if (delivery) begin
         hold_d = 1'b0;
      end

      // Results still draining from before a reset must not wrap the credit count.
      cnt_next = int'(inflight_q) + int'(grant_any) - int'(delivery) - int'(res_drop);
      if (cnt_next < 0) cnt_next = 0;
      inflight_d = CNT_WIDTH'(cnt_next);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q       <= '0;
         inflight_q  <= '0;
         eng_valid_q <= 1'b0;
         eng_tag_q   <= '0;
         eng_data_q  <= '0;
         hold_q      <= 1'b0;
         out_id_q    <= '0;
         out_tag_q   <= '0;
         out_data_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         ptr_q       <= ptr_d;
         inflight_q  <= inflight_d;
         eng_valid_q <= eng_valid_d;
         eng_tag_q   <= eng_tag_d;
         eng_data_q  <= eng_data_d;
         hold_q      <= hold_d;
         out_id_q    <= out_id_d;
         out_tag_q   <= out_tag_d;
         out_data_q  <= out_data_d;
         err_q       <= err_d;
      end
   end

   assign bus.req_ready = grant;
   assign bus.eng_valid = eng_valid_q;
   assign bus.eng_tag   = eng_tag_q;
   assign bus.eng_data  = eng_data_q;
   assign bus.res_ready = res_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_tag   = out_tag_q;
   assign bus.out_data  = out_data_q;
   assign bus.busy      = (inflight_q != '0) || eng_valid_q;
   assign bus.err       = err_q;
endmodule
